mdu_ctrl: RTL and testbench

Multiply/divide unit sequencer for the pipelined MIPS core. It accepts HI/LO-class instructions from the E stage and runs multi-cycle multiply and divide operations. It owns the HI and LO registers and raises the stall request that holds D-stage HI/LO instructions while an operation is in flight.

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 tb/tb_mdu_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> multiply/divide unit bundle: operation request, operands, and the HI/LO/stall results.
interface mdu_ctrl_if;
   logic [3:0]  md_op;
   logic        md_valid;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_md;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_op, md_valid, rs_val, rt_val, d_md,
      input  start, busy, stall, hi, lo
   );

   modport slave (
      input  md_op, md_valid, rs_val, rt_val, d_md,
      output start, busy, stall, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the 64-bit result at accept, holds it pending for a fixed
// number of busy cycles, then commits it to HI/LO.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   mdu_ctrl_if.slave   bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [3:0] OP_MULT  = 4'd1,  OP_MULTU = 4'd2,  OP_DIV   = 4'd3,  OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5,  OP_MTLO  = 4'd6,  OP_MADD  = 4'd7,  OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9,  OP_MSUBU = 4'd10;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [63:0]   pend_reg, pend_next;
   logic [31:0]   hi_reg, hi_next;
   logic [31:0]   lo_reg, lo_next;

   logic        is_multi, is_div;
   logic [63:0] prod_s, prod_u, acc, result;
   logic [31:0] divisor, quot_s, rem_s;

   always_comb begin
      is_multi = 1'b0;
      case (bus.md_op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
         default:                              is_multi = 1'b0;
      endcase
   end

   assign is_div    = (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);
   assign bus.start = bus.md_valid && is_multi && (state_reg == IDLE);
   assign bus.busy  = (state_reg == BUSY);
   assign bus.stall = bus.d_md && (bus.start || bus.busy);
   assign bus.hi    = hi_reg;
   assign bus.lo    = lo_reg;

   assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
   assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
   assign acc    = {hi_reg, lo_reg};

   // Zero divisor is replaced so the divider never sees it; that case is overridden below anyway.
   assign divisor = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
   assign quot_s  = $signed(bus.rs_val) / $signed(divisor);
   assign rem_s   = $signed(bus.rs_val) % $signed(divisor);

   always_comb begin
      result = 64'd0;
      case (bus.md_op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_MADD:  result = acc + prod_s;
         OP_MADDU: result = acc + prod_u;
         OP_MSUB:  result = acc - prod_s;
         OP_MSUBU: result = acc - prod_u;
         OP_DIV: begin
            if (bus.rt_val == 32'd0)
               result = {bus.rs_val, 32'hFFFF_FFFF};
            else if (bus.rs_val == 32'h8000_0000 && bus.rt_val == 32'hFFFF_FFFF)
               result = {32'd0, 32'h8000_0000};
            else
               result = {rem_s, quot_s};
         end
         OP_DIVU: begin
            if (bus.rt_val == 32'd0)
               result = {bus.rs_val, 32'hFFFF_FFFF};
            else
               result = {bus.rs_val % bus.rt_val, bus.rs_val / bus.rt_val};
         end
         default:  result = 64'd0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               pend_next  = result;
               cnt_next   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
               state_next = BUSY;
            end else if (bus.md_valid && bus.md_op == OP_MTHI) begin
               hi_next = bus.rs_val;
            end else if (bus.md_valid && bus.md_op == OP_MTLO) begin
               lo_next = bus.rs_val;
            end
         end
         BUSY: begin
            // Anything issued while busy is deliberately ignored.
            if (cnt_reg == '0) begin
               {hi_next, lo_next} = pend_reg;
               state_next         = IDLE;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         pend_reg  <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain two's-complement arithmetic; division via magnitudes and sign fix-up.
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
      longint      sp;
      logic [63:0] up;
      logic [31:0] ma, mb, q, r;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = 64'(a) * 64'(b);
      case (op)
         4'd1:  return 64'(sp);
         4'd2:  return up;
         4'd7:  return acc + 64'(sp);
         4'd8:  return acc + up;
         4'd9:  return acc - 64'(sp);
         4'd10: return acc - up;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            ma = a[31] ? -a : a;
            mb = b[31] ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (a[31] ^ b[31]) q = -q;
            if (a[31]) r = -r;
            return {r, q};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return acc;
      endcase
   endfunction

   task automatic idle_inputs();
      bus.md_op    = 4'd0;
      bus.md_valid = 1'b0;
      bus.rs_val   = '0;
      bus.rt_val   = '0;
   endtask

   task automatic run_mc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd);
      logic [63:0] exp;
      int n;
      n   = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
      exp = ref_result(op, a, b, {model_hi, model_lo});
      @(negedge clk);
      bus.md_op = op; bus.md_valid = 1'b1; bus.rs_val = a; bus.rt_val = b; bus.d_md = dmd;
      #1;
      chk("start", 32'(bus.start), 32'd1);
      chk("stall_at_start", 32'(bus.stall), 32'(dmd));
      @(posedge clk); #1;
      idle_inputs();
      for (int i = 0; i < n; i++) begin
         chk("busy_high", 32'(bus.busy), 32'd1);
         chk("stall_busy", 32'(bus.stall), 32'(dmd));
         @(posedge clk); #1;
      end
      chk("busy_fall", 32'(bus.busy), 32'd0);
      chk("stall_fall", 32'(bus.stall), 32'd0);
      chk("hi", bus.hi, exp[63:32]);
      chk("lo", bus.lo, exp[31:0]);
      {model_hi, model_lo} = exp;
      bus.d_md = 1'b0;
      $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
   endtask

   task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
      @(negedge clk);
      bus.md_op = op; bus.md_valid = 1'b1; bus.rs_val = a;
      #1;
      chk("mt_no_start", 32'(bus.start), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      if (op == 4'd5) model_hi = a; else model_lo = a;
      chk("mt_hi", bus.hi, model_hi);
      chk("mt_lo", bus.lo, model_lo);
      chk("mt_busy", 32'(bus.busy), 32'd0);
      $display("op=%0d rs=%h -> hi=%h lo=%h", op, a, bus.hi, bus.lo);
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] specials [4];
      specials[0] = 32'h0000_0000; specials[1] = 32'h8000_0000;
      specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h0000_0001;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      logic [63:0] exp;
      logic [3:0]  ops [10];
      ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd5, 4'd6};

      reset = 1'b0;
      idle_inputs();
      bus.d_md = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_start", 32'(bus.start), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      bus.d_md = 1'b0;

      run_mc(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_mc(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_mc(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_mc(4'd4, 32'd7, 32'd0, 1'b0);
      run_mc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_mt(4'd5, 32'd0);
      run_mt(4'd6, 32'd5);
      run_mc(4'd7, 32'd3, 32'd4, 1'b0);
      run_mt(4'd6, 32'd0);
      run_mc(4'd9, 32'd1, 32'd1, 1'b0);
      run_mc(4'd1, 32'd7, 32'd9, 1'b1);
      run_mc(4'd3, 32'd12, 32'hFFFF_FFFB, 1'b0);

      // Operations issued while busy must be ignored.
      exp = ref_result(4'd1, 32'd3, 32'd5, {model_hi, model_lo});
      @(negedge clk);
      bus.md_op = 4'd1; bus.md_valid = 1'b1; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
      #1;
      chk("ign_start", 32'(bus.start), 32'd1);
      @(posedge clk); #1;
      bus.md_op = 4'd5; bus.rs_val = 32'hDEAD_BEEF;
      #1;
      chk("ign_mthi_start", 32'(bus.start), 32'd0);
      @(posedge clk); #1;
      chk("ign_mthi_hi", bus.hi, model_hi);
      bus.md_op = 4'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      #1;
      chk("ign_div_start", 32'(bus.start), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      for (int i = 2; i < MULT_N; i++) begin
         chk("ign_busy", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
      end
      chk("ign_busy_fall", 32'(bus.busy), 32'd0);
      chk("ign_hi", bus.hi, exp[63:32]);
      chk("ign_lo", bus.lo, exp[31:0]);
      {model_hi, model_lo} = exp;
      $display("busy-ignore: hi=%h lo=%h", bus.hi, bus.lo);

      // Reset in the middle of a divide aborts it.
      run_mt(4'd5, 32'h1234_5678);
      @(negedge clk);
      bus.md_op = 4'd3; bus.md_valid = 1'b1; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      model_hi = '0;
      model_lo = '0;
      repeat (DIV_N) @(posedge clk);
      #1;
      chk("abort_stays_hi", bus.hi, 32'd0);
      chk("abort_stays_busy", 32'(bus.busy), 32'd0);
      $display("reset-abort: hi=%h lo=%h", bus.hi, bus.lo);
      run_mc(4'd1, 32'd6, 32'd7, 1'b1);

      for (int k = 0; k < 30; k++) begin
         logic [3:0] op;
         op = ops[$urandom_range(0, 9)];
         if (op == 4'd5 || op == 4'd6) run_mt(op, $urandom);
         else run_mc(op, pick_val(), pick_val(), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
